sonar_varredura_ctrl: RTL and testbench
=======================================

Name: sonar_varredura_ctrl

Overview:
- Parametrised sweep controller for the sonar: steps a servo through N_POS positions and waits a settle time at each one.
- At each position it requests one ultrasonic measurement and sends an ASCII frame "AAA,DDD#" (angle, distance) byte by byte to the UART transmitter.
- Successor of the fixed 8-position, wrap-only controller. Adds:
  - ping-pong sweep mode;
  - measurement timeout with error reporting;
  - parametrised position count, angle table and timing.
- Sits between the top level and the existing sensor-interface, servo and UART blocks.

Parameters:
- N_POS, 8, number of servo positions (2..16)
- POS_W, 3, width of posicao; must satisfy 2**POS_W >= N_POS
- SETTLE_CYCLES, 100000000, clock cycles spent in ESPERA_SERVO at each position
- TIMEOUT_CYCLES, 2500000, maximum wait for pronto_medida
- ANG_START, 20, angle of position 0 in degrees
- ANG_STEP, 20, degrees between consecutive positions; ANG_START+(N_POS-1)*ANG_STEP <= 999

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ligar  in  1  level; 1 = sweep enabled
- modo  in  1  0 = wrap sweep (0..N-1,0..), 1 = ping-pong sweep (0..N-1..0..)
- pronto_medida  in  1  one-cycle pulse from sensor interface
- distancia  in  12  BCD distance in cm, 3 digits, valid when pronto_medida=1
- pronto_tx  in  1  one-cycle pulse from UART when a byte has finished
- medir  out  1  one-cycle measurement request
- partida_tx  out  1  one-cycle UART start
- dado_tx  out  7  ASCII byte, held stable from partida_tx until pronto_tx
- posicao  out  POS_W  current servo position index
- fim_posicao  out  1  one-cycle pulse after each frame completes
- erro_medida  out  1  sticky flag, set on timeout
- db_estado  out  4  FSM state code

Behaviour:
- Reset values: all outputs 0, posicao=0, direction=up, FSM in INICIAL. Reset mid-operation aborts immediately.
- States and transitions (codes 0..8):
  - INICIAL(0): wait for ligar=1 -> PREPARA.
  - PREPARA(1): clear timer, posicao=0, dir=up, clear erro_medida -> ESPERA_SERVO.
  - ESPERA_SERVO(2): count to SETTLE_CYCLES-1, then -> MEDE. If ligar=0 here -> INICIAL.
  - MEDE(3): medir=1 for one cycle, clear timer -> AGUARDA_MEDIDA.
  - AGUARDA_MEDIDA(4):
    - On pronto_medida: latch distancia -> CARREGA.
    - On timer reaching TIMEOUT_CYCLES-1 without pronto_medida: latch 12'h999, set erro_medida -> CARREGA.
    - If pronto_medida arrives on the timeout cycle, the measurement wins.
  - CARREGA(5): byte index=0; load frame byte 0 into dado_tx -> TRANSMITE.
  - TRANSMITE(6): partida_tx=1 for one cycle -> AGUARDA_TX.
  - AGUARDA_TX(7): on pronto_tx:
    - if index=7 -> PROXIMA;
    - else index+1, load next byte -> TRANSMITE.
  - PROXIMA(8): fim_posicao=1, update posicao/dir, clear timer.
    - Then -> ESPERA_SERVO if ligar=1, else INICIAL with posicao=0.
- Frame bytes, in order:
  - three angle digits (hundreds first), each 0x30+digit;
  - ',' (0x2C);
  - three distance digits from the latched value, hundreds first;
  - '#' (0x23).
- Angle digits come from a constant BCD table indexed by posicao: ANG_START+posicao*ANG_STEP.
- Position update:
  - modo=0: posicao = (posicao==N_POS-1) ? 0 : posicao+1.
  - modo=1: at N_POS-1 dir flips to down and posicao becomes N_POS-2; at 0 dir flips to up and posicao becomes 1. No position is repeated at the ends.
  - modo is sampled only in PROXIMA. Switching modo to 0 while moving down continues from posicao+1, dir=up.
- ligar=0 outside ESPERA_SERVO/PROXIMA: the current frame completes first.
- erro_medida stays set until PREPARA or reset.
- Latency: ligar rising -> first medir pulse takes SETTLE_CYCLES+2 cycles.

Decomposition:
- Package sonar_pkg holds:
  - state encoding constants (0..8, shared with db_estado decoding on the displays);
  - ASCII constants for ',', '#' and '0';
  - elaboration-time function ang_bcd(pos) returning 12-bit BCD.
- One sub-module: sonar_frame_mux. It is combinational: index[2:0] plus angle BCD plus distance BCD in, 7-bit ASCII out.
- Timer and position counters stay inline.

Test Plan:
- Params N_POS=4, SETTLE=10, TIMEOUT=50, START=20, STEP=20, modo=0. Set ligar=1; sensor returns 12'h123 after 5 cycles. Required:
  - first medir at cycle 12 after ligar;
  - bytes "020,123#" = 30 32 30 2C 31 32 33 23;
  - posicao sequence 0,1,2,3,0.
- Same parameters, modo=1, 8 frames -> posicao 0,1,2,3,2,1,0,1; angles 020,040,060,080,060,040,020,040.
- Sensor never responds -> after 50 cycles the frame "020,999#" is sent, erro_medida=1 and stays 1; next position proceeds normally.
- pronto_medida on exactly the timeout cycle with 12'h045 -> frame "…,045#" is sent and erro_medida stays 0.
- Drop ligar during byte 3 of the frame -> all 8 bytes are sent, then fim_posicao pulses, FSM goes to INICIAL with posicao=0 and no further medir.
- Assert reset during AGUARDA_TX -> the next cycle has all outputs 0 and db_estado=0; no partida_tx afterwards.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: FSM state codes (also decoded
// on the debug displays), frame ASCII constants and the angle BCD helper.
package sonar_pkg;

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      ESPERA_SERVO   = 4'd2,
      MEDE           = 4'd3,
      AGUARDA_MEDIDA = 4'd4,
      CARREGA        = 4'd5,
      TRANSMITE      = 4'd6,
      AGUARDA_TX     = 4'd7,
      PROXIMA        = 4'd8
   } estado_t;

   localparam logic [6:0]  ASC_ZERO      = 7'h30;
   localparam logic [6:0]  ASC_VIRGULA   = 7'h2C;
   localparam logic [6:0]  ASC_CERQUILHA = 7'h23;
   localparam logic [11:0] DIST_ERRO     = 12'h999;

   // Three-digit BCD of start + pos*step; evaluated at elaboration to build the angle table.
   function automatic logic [11:0] ang_bcd(input int pos, input int start, input int step);
      int v;
      v = (start + pos * step) % 1000;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/sonar_frame_mux.sv
// Selects one ASCII byte of the "AAA,DDD#" frame from the byte index,
// the angle BCD and the latched distance BCD.
module sonar_frame_mux
   import sonar_pkg::*;
(
   input  logic [2:0]  i_idx,
   input  logic [11:0] i_ang,
   input  logic [11:0] i_dist,
   output logic [6:0]  o_byte
);

   function automatic logic [6:0] digito(input logic [3:0] d);
      return ASC_ZERO + {3'b000, d};
   endfunction

   always_comb begin
      o_byte = ASC_CERQUILHA;
      case (i_idx)
         3'd0:    o_byte = digito(i_ang[11:8]);
         3'd1:    o_byte = digito(i_ang[7:4]);
         3'd2:    o_byte = digito(i_ang[3:0]);
         3'd3:    o_byte = ASC_VIRGULA;
         3'd4:    o_byte = digito(i_dist[11:8]);
         3'd5:    o_byte = digito(i_dist[7:4]);
         3'd6:    o_byte = digito(i_dist[3:0]);
         default: o_byte = ASC_CERQUILHA;
      endcase
   end

endmodule

// File: rtl/sonar_varredura_ctrl.sv
// Sonar sweep controller: steps the servo through N_POS positions (wrap or ping-pong),
// requests a measurement at each one and streams an "AAA,DDD#" frame to the UART.
module sonar_varredura_ctrl
   import sonar_pkg::*;
#(
   parameter int N_POS          = 8,
   parameter int POS_W          = 3,
   parameter int SETTLE_CYCLES  = 100000000,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int ANG_START      = 20,
   parameter int ANG_STEP       = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic             modo,
   input  logic             pronto_medida,
   input  logic [11:0]      distancia,
   input  logic             pronto_tx,
   output logic             medir,
   output logic             partida_tx,
   output logic [6:0]       dado_tx,
   output logic [POS_W-1:0] posicao,
   output logic             fim_posicao,
   output logic             erro_medida,
   output logic [3:0]       db_estado
);

   localparam int               N_TAB       = 1 << POS_W;
   localparam logic [POS_W-1:0] POS_ULT     = POS_W'(N_POS - 1);
   localparam logic [31:0]      SETTLE_FIM  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0]      TIMEOUT_FIM = 32'(TIMEOUT_CYCLES - 1);

   estado_t          r_estado;
   logic [31:0]      r_timer;
   logic [POS_W-1:0] r_posicao;
   logic             r_desce;
   logic [2:0]       r_idx;
   logic [11:0]      r_dist;
   logic             r_medir;
   logic             r_partida;
   logic             r_fim;
   logic             r_erro;
   logic [6:0]       r_dado;

   logic [11:0]      w_ang_tab [N_TAB];
   logic [11:0]      w_ang;
   logic [2:0]       w_mux_idx;
   logic [6:0]       w_byte;
   logic [POS_W-1:0] w_pos_prox;
   logic             w_desce_prox;

   for (genvar g = 0; g < N_TAB; g++) begin : g_ang
      assign w_ang_tab[g] = ang_bcd(g, ANG_START, ANG_STEP);
   end

   assign w_ang = w_ang_tab[r_posicao];

   // The byte register is loaded one state ahead of TRANSMITE, so look at the index being moved to.
   assign w_mux_idx = (r_estado == AGUARDA_TX) ? r_idx + 3'd1 : 3'd0;

   sonar_frame_mux u_frame_mux (
      .i_idx  (w_mux_idx),
      .i_ang  (w_ang),
      .i_dist (r_dist),
      .o_byte (w_byte)
   );

   // Default step is +1/up; only the two turn-around cases and the downward walk differ.
   always_comb begin
      w_pos_prox   = r_posicao + POS_W'(1);
      w_desce_prox = 1'b0;
      if (!modo) begin
         if (r_posicao == POS_ULT) w_pos_prox = '0;
      end else if (!r_desce) begin
         if (r_posicao == POS_ULT) begin
            w_pos_prox   = r_posicao - POS_W'(1);
            w_desce_prox = 1'b1;
         end
      end else if (r_posicao != '0) begin
         w_pos_prox   = r_posicao - POS_W'(1);
         w_desce_prox = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (r_estado == AGUARDA_MEDIDA) begin
         if (pronto_medida)               r_dist <= distancia;
         else if (r_timer == TIMEOUT_FIM) r_dist <= DIST_ERRO;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado  <= INICIAL;
         r_timer   <= '0;
         r_posicao <= '0;
         r_desce   <= 1'b0;
         r_idx     <= '0;
         r_medir   <= 1'b0;
         r_partida <= 1'b0;
         r_fim     <= 1'b0;
         r_erro    <= 1'b0;
         r_dado    <= '0;
      end else begin
         r_medir   <= 1'b0;
         r_partida <= 1'b0;
         r_fim     <= 1'b0;
         case (r_estado)
            INICIAL: if (ligar) r_estado <= PREPARA;
            PREPARA: begin
               r_timer   <= '0;
               r_posicao <= '0;
               r_desce   <= 1'b0;
               r_erro    <= 1'b0;
               r_estado  <= ESPERA_SERVO;
            end
            ESPERA_SERVO: begin
               if (!ligar) begin
                  r_estado <= INICIAL;
               end else if (r_timer == SETTLE_FIM) begin
                  r_medir  <= 1'b1;
                  r_estado <= MEDE;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            MEDE: begin
               r_timer  <= '0;
               r_estado <= AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
               // A measurement arriving on the timeout cycle takes priority over the error.
               if (pronto_medida) begin
                  r_estado <= CARREGA;
               end else if (r_timer == TIMEOUT_FIM) begin
                  r_erro   <= 1'b1;
                  r_estado <= CARREGA;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            CARREGA: begin
               r_idx     <= '0;
               r_dado    <= w_byte;
               r_partida <= 1'b1;
               r_estado  <= TRANSMITE;
            end
            TRANSMITE: r_estado <= AGUARDA_TX;
            AGUARDA_TX: begin
               if (pronto_tx) begin
                  if (r_idx == 3'd7) begin
                     r_fim    <= 1'b1;
                     r_estado <= PROXIMA;
                  end else begin
                     r_idx     <= r_idx + 3'd1;
                     r_dado    <= w_byte;
                     r_partida <= 1'b1;
                     r_estado  <= TRANSMITE;
                  end
               end
            end
            PROXIMA: begin
               r_timer <= '0;
               if (ligar) begin
                  r_posicao <= w_pos_prox;
                  r_desce   <= w_desce_prox;
                  r_estado  <= ESPERA_SERVO;
               end else begin
                  r_posicao <= '0;
                  r_desce   <= 1'b0;
                  r_estado  <= INICIAL;
               end
            end
            default: r_estado <= INICIAL;
         endcase
      end
   end

   assign medir       = r_medir;
   assign partida_tx  = r_partida;
   assign dado_tx     = r_dado;
   assign posicao     = r_posicao;
   assign fim_posicao = r_fim;
   assign erro_medida = r_erro;
   assign db_estado   = r_estado;

endmodule

// File: tb/tb_sonar_varredura_ctrl.sv
// Bench for sonar_varredura_ctrl with N_POS=4, SETTLE=10, TIMEOUT=50: a scoreboard of
// expected frame bytes and per-frame position/error, popped by a negedge monitor.
module tb_sonar_varredura_ctrl;

   logic       clock;
   logic       reset;
   logic       ligar;
   logic       modo;
   logic       pronto_medida;
   logic [11:0] distancia;
   logic       pronto_tx;
   logic       medir;
   logic       partida_tx;
   logic [6:0] dado_tx;
   logic [1:0] posicao;
   logic       fim_posicao;
   logic       erro_medida;
   logic [3:0] db_estado;

   int n_pass = 0;
   int n_total = 0;
   int n_medir = 0;
   int n_partida = 0;
   int n_fim = 0;

   int q_byte[$];
   int q_pos[$];
   int q_erro[$];
   int q_plan_k[$];
   logic [11:0] q_plan_v[$];

   sonar_varredura_ctrl #(
      .N_POS(4), .POS_W(2), .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(50),
      .ANG_START(20), .ANG_STEP(20)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
      .pronto_medida(pronto_medida), .distancia(distancia), .pronto_tx(pronto_tx),
      .medir(medir), .partida_tx(partida_tx), .dado_tx(dado_tx), .posicao(posicao),
      .fim_posicao(fim_posicao), .erro_medida(erro_medida), .db_estado(db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nome, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
   endtask

   // k = cycles until the sensor answers (-1: never); ang given in decimal degrees.
   task automatic plan(input int k, input logic [11:0] v, input int pos, input int ang, input int erro);
      logic [11:0] d;
      d = (k < 0) ? 12'h999 : v;
      q_plan_k.push_back(k);
      q_plan_v.push_back(v);
      q_byte.push_back(48 + ang / 100);
      q_byte.push_back(48 + (ang / 10) % 10);
      q_byte.push_back(48 + ang % 10);
      q_byte.push_back(44);
      q_byte.push_back(48 + int'(d[11:8]));
      q_byte.push_back(48 + int'(d[7:4]));
      q_byte.push_back(48 + int'(d[3:0]));
      q_byte.push_back(35);
      q_pos.push_back(pos);
      q_erro.push_back(erro);
   endtask

   task automatic wait_fims(input int n, input int max_cyc);
      int alvo;
      alvo = n_fim + n;
      for (int i = 0; i < max_cyc && n_fim < alvo; i++) @(negedge clock);
      chk("espera_fim_posicao", n_fim, alvo);
   endtask

   task automatic wait_bytes(input int alvo, input int max_cyc);
      for (int i = 0; i < max_cyc && n_partida < alvo; i++) @(negedge clock);
      chk("espera_bytes", n_partida, alvo);
   endtask

   task automatic wait_estado(input int st, input int max_cyc);
      for (int i = 0; i < max_cyc && int'(db_estado) != st; i++) @(negedge clock);
      chk("espera_estado", 32'(db_estado), st);
   endtask

   task automatic chk_zerado(input string fase);
      chk({fase, "_medir"}, 32'(medir), 0);
      chk({fase, "_partida_tx"}, 32'(partida_tx), 0);
      chk({fase, "_dado_tx"}, 32'(dado_tx), 0);
      chk({fase, "_posicao"}, 32'(posicao), 0);
      chk({fase, "_fim_posicao"}, 32'(fim_posicao), 0);
      chk({fase, "_erro_medida"}, 32'(erro_medida), 0);
      chk({fase, "_db_estado"}, 32'(db_estado), 0);
   endtask

   // Scoreboard monitor
   always @(negedge clock) begin
      int e;
      if (!reset) begin
         if (medir) n_medir++;
         if (partida_tx) begin
            n_partida++;
            e = (q_byte.size() > 0) ? q_byte.pop_front() : 255;
            chk("dado_tx", 32'(dado_tx), e);
         end
         if (fim_posicao) begin
            n_fim++;
            e = (q_pos.size() > 0) ? q_pos.pop_front() : 255;
            chk("posicao_fim", 32'(posicao), e);
            e = (q_erro.size() > 0) ? q_erro.pop_front() : 255;
            chk("erro_medida_fim", 32'(erro_medida), e);
         end
      end
   end

   // Sensor model
   initial begin
      int k;
      logic [11:0] v;
      pronto_medida = 1'b0;
      distancia = '0;
      forever begin
         @(negedge clock);
         if (medir && !reset) begin
            k = -1;
            v = '0;
            if (q_plan_k.size() > 0) begin
               k = q_plan_k.pop_front();
               v = q_plan_v.pop_front();
            end
            if (k >= 0) begin
               repeat (k) @(posedge clock);
               #1 pronto_medida = 1'b1;
               distancia = v;
               @(posedge clock);
               #1 pronto_medida = 1'b0;
            end
         end
      end
   end

   // UART model: byte done 4 cycles after the start pulse
   initial begin
      pronto_tx = 1'b0;
      forever begin
         @(negedge clock);
         if (partida_tx && !reset) begin
            repeat (3) @(posedge clock);
            #1 pronto_tx = 1'b1;
            @(posedge clock);
            #1 pronto_tx = 1'b0;
         end
      end
   end

   initial begin
      int cyc;
      int m0;
      int p0;
      reset = 1'b1;
      ligar = 1'b0;
      modo  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_zerado("reset");
      @(posedge clock);
      #1 reset = 1'b0;

      // Wrap sweep: 0,1,2,3,0; ligar dropped during byte 3 of the fifth frame
      plan(5, 12'h123, 0, 20, 0);
      plan(5, 12'h456, 1, 40, 0);
      plan(5, 12'h789, 2, 60, 0);
      plan(5, 12'h007, 3, 80, 0);
      plan(5, 12'h310, 0, 20, 0);
      @(posedge clock);
      #1 ligar = 1'b1;
      cyc = 0;
      while (!medir && cyc < 100) begin
         @(posedge clock);
         #1 cyc++;
      end
      chk("latencia_medir", cyc, 12);
      wait_fims(4, 2000);
      wait_bytes(35, 500);
      ligar = 1'b0;
      wait_fims(1, 500);
      m0 = n_medir;
      repeat (40) @(negedge clock);
      chk("desliga_estado", 32'(db_estado), 0);
      chk("desliga_posicao", 32'(posicao), 0);
      chk("desliga_sem_medir", n_medir, m0);

      // Ping-pong sweep, timeout-cycle measurement win, then a real timeout
      modo = 1'b1;
      plan(50, 12'h045, 0, 20, 0);
      plan(-1, 12'h000, 1, 40, 1);
      plan(5, 12'h222, 2, 60, 1);
      plan(5, 12'h333, 3, 80, 1);
      plan(5, 12'h444, 2, 60, 1);
      plan(5, 12'h555, 1, 40, 1);
      plan(5, 12'h666, 0, 20, 1);
      plan(5, 12'h777, 1, 40, 1);
      @(posedge clock);
      #1 ligar = 1'b1;
      wait_fims(8, 4000);
      chk("bytes_pendentes", q_byte.size(), 0);
      chk("medidas_pendentes", q_plan_k.size(), 0);

      // Reset while waiting for the UART
      plan(5, 12'h111, 2, 60, 1);
      wait_estado(7, 500);
      @(posedge clock);
      #1 reset = 1'b1;
      ligar = 1'b0;
      @(posedge clock);
      #1 chk_zerado("reset_tx");
      q_byte.delete();
      q_pos.delete();
      q_erro.delete();
      q_plan_k.delete();
      q_plan_v.delete();
      p0 = n_partida;
      m0 = n_medir;
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (30) @(negedge clock);
      chk("reset_sem_partida", n_partida, p0);
      chk("reset_sem_medir", n_medir, m0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
